// File: rtl/mtl_timing_gen.sv
// mtl_timing_gen -- raster timing generator for the 800x480 MTL LCD panel.
//
// Owns the free-running Xpos/Ypos pixel counters consumed by the shape
// renderers and produces registered panel controls: hsd/vsd (active-low
// sync), den (data enable) and a one-clock frame_start pulse at (0,0).
//
// Build option MTL_TIMING_DLY_EN:
//   defined   - a PIPE_DLY-stage delay line (legal 1..4) follows the decode
//               register, giving control latency 1+PIPE_DLY so den lines up
//               with the renderer's registered RGB.
//   undefined - the decode register drives the outputs (latency 1) and
//               PIPE_DLY has no effect.
//
// Reset is asynchronous and active-high; on assertion the counters clear and
// every control stage returns to idle (hsd=1, vsd=1, den=0, frame_start=0).

module mtl_timing_gen #(
    parameter int H_TOTAL  = 1056,
    parameter int V_TOTAL  = 525,
    parameter int H_SYNC   = 30,
    parameter int H_BACK   = 16,
    parameter int H_ACTIVE = 800,
    parameter int V_SYNC   = 13,
    parameter int V_BACK   = 10,
    parameter int V_ACTIVE = 480,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] Xpos,
    output logic [9:0]  Ypos,
    output logic        hsd,
    output logic        vsd,
    output logic        den,
    output logic        frame_start
);

    // One bundle of panel controls, carried together through every stage.
    typedef struct packed {
        logic hsd;
        logic vsd;
        logic den;
        logic fs;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hsd: 1'b1, vsd: 1'b1, den: 1'b0, fs: 1'b0};

    // Counter wrap points.
    localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);

    // Decode boundaries, held at 12 bits so the sums cannot overflow.
    localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
    localparam logic [11:0] H_DEN_FIRST = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_DEN_LAST  = 12'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [11:0] V_DEN_FIRST = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_DEN_LAST  = 12'(V_SYNC + V_BACK + V_ACTIVE - 1);

    // Number of delay stages after the decode register; zero when the
    // option is off, in which case PIPE_DLY has no effect.
`ifdef MTL_TIMING_DLY_EN
    localparam int DLY_STAGES = PIPE_DLY;
`else
    localparam int DLY_STAGES = PIPE_DLY * 0;
`endif

    logic [11:0] x_ext;
    logic [11:0] y_ext;
    ctrl_t       dec_d;
    ctrl_t       dec_q;
    ctrl_t       ctrl_out;

    // Raster counters: X steps every clock, Y steps on the X wrap, and both
    // return to zero together on the last pixel of the frame.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use <= so each one samples pre-edge values; with =
        // the Y update would see the X value already written in this edge.
        if (reset) begin
            Xpos <= '0;
            Ypos <= '0;
        end else if (Xpos == X_LAST) begin
            Xpos <= '0;
            Ypos <= (Ypos == Y_LAST) ? '0 : Ypos + 10'd1;
        end else begin
            Xpos <= Xpos + 11'd1;
        end
    end

    assign x_ext = {1'b0, Xpos};
    assign y_ext = {2'b0, Ypos};

    // Combinational decode of the current counter position.
    always_comb begin
        // NOTE: default first so every path assigns every field; a missed
        // field would otherwise infer a latch.
        dec_d     = CTRL_IDLE;
        dec_d.hsd = !(x_ext < H_SYNC_END);
        dec_d.vsd = !(y_ext < V_SYNC_END);
        dec_d.den = (x_ext >= H_DEN_FIRST) && (x_ext <= H_DEN_LAST) &&
                    (y_ext >= V_DEN_FIRST) && (y_ext <= V_DEN_LAST);
        dec_d.fs  = (Xpos == 11'd0) && (Ypos == 10'd0);
    end

    // Decode register: controls for counter value N appear at cycle N+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q <= CTRL_IDLE;
        end else begin
            dec_q <= dec_d;
        end
    end

    // Optional alignment delay line; shifts every clock, no stall.
    if (DLY_STAGES > 0) begin : g_dly
        ctrl_t dly_q [DLY_STAGES];

        // Shift register of control bundles, all stages idle on reset.
        always_ff @(posedge clk or posedge reset) begin
            // NOTE: this small array is reset on purpose: its stages reach the
            // panel pins, so stale contents would emit a partial pulse.
            if (reset) begin
                for (int i = 0; i < DLY_STAGES; i++) begin
                    dly_q[i] <= CTRL_IDLE;
                end
            end else begin
                dly_q[0] <= dec_q;
                for (int i = 1; i < DLY_STAGES; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign ctrl_out = dly_q[DLY_STAGES-1];
    end else begin : g_nodly
        assign ctrl_out = dec_q;
    end

    assign hsd         = ctrl_out.hsd;
    assign vsd         = ctrl_out.vsd;
    assign den         = ctrl_out.den;
    assign frame_start = ctrl_out.fs;

endmodule
